if_stage: RTL
=============

Name: if_stage

Overview:
Instruction fetch stage of the 5-stage pipeline. It owns the program counter and drives the byte address into the combinational instruction memory. It captures the returned instruction, with its PC, into the IF/ID pipeline register consumed by decode. It honours stall and flush requests from the hazard unit and taken-branch/jump redirects from EX.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) inserted into IF/ID.

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
o_imem_addr  output  32  byte address to instruction memory (current PC)
i_imem_instr  input  32  instruction returned combinationally for o_imem_addr
i_stall  input  1  hold PC and IF/ID contents
i_flush  input  1  replace IF/ID contents with bubble
i_redirect  input  1  taken branch/jump from EX
i_redirect_pc  input  32  redirect target byte address
o_id_valid  output  1  IF/ID holds a real instruction
o_id_pc  output  32  PC of the IF/ID instruction
o_id_pc_plus4  output  32  o_id_pc + 4 (link value)
o_id_instr  output  32  IF/ID instruction

Behaviour:
- Single clock domain. Reset is asynchronous and active-low: i_rst_n low forces state immediately, independent of i_clk.
- Reset values:
  - PC = RESET_PC, so o_imem_addr = RESET_PC.
  - o_id_valid = 0, o_id_pc = 0, o_id_pc_plus4 = 0, o_id_instr = NOP_INSTR.
- o_imem_addr = PC register, driven directly from the flop with no combinational path from inputs.
- Fetch latency: the instruction at PC appears on o_id_* on the rising edge after the PC is presented, so 1 cycle.
- PC next-state, in priority order:
  - i_redirect=1: PC <= {i_redirect_pc[31:2], 2'b00}. Low two bits are silently dropped. Redirect overrides i_stall.
  - else i_stall=1: PC holds.
  - else: PC <= PC + 4. 32-bit modular, so 0xFFFF_FFFC wraps to 0x0000_0000.
- IF/ID next-state, in priority order:
  - i_redirect=1 or i_flush=1: bubble. valid=0, instr=NOP_INSTR, pc and pc_plus4 hold their previous value.
  - else i_stall=1: all IF/ID fields hold.
  - else: valid=1, pc=PC, pc_plus4=PC+4 (wrapping), instr=i_imem_instr.
- Simultaneous events:
  - i_stall with i_flush: IF/ID becomes a bubble; PC holds.
  - i_redirect with i_stall: redirect wins for both PC and IF/ID.
  - i_flush alone: PC advances normally.
- First cycle after reset deassertion: fetches RESET_PC. o_id_valid first rises on the following edge, assuming no stall, flush or redirect.
- Reset asserted mid-run: all state returns to reset values at once; any in-flight IF/ID contents are discarded.
- No handshake with memory: i_imem_instr is assumed valid in the same cycle as o_imem_addr.
- Inputs are sampled only at rising edges; no glitch filtering.

Decomposition:
- Shared package (riscv_pkg): NOP_INSTR constant, and typedef if_id_t (valid, pc, pc_plus4, instr).
- Sub-module if_id_reg: the IF/ID pipeline register with hold and bubble controls. It is reused for the stall/flush pattern of later stage registers.
- PC register and next-PC logic stay in if_stage.

Test Plan:
1. Reset then release, memory words 0..3 = 0x00500093, 0x00A00113, 0x002081B3, 0x00000013 -> o_imem_addr steps 0,4,8,C. o_id_valid=0 for the first edge, then o_id_instr = 0x00500093 with o_id_pc=0 and o_id_pc_plus4=4, and so on.
2. Assert i_stall for 2 cycles while PC=8 -> o_imem_addr stays 8 and o_id_pc/o_id_instr stay frozen at PC 4. On release, PC goes to C and IF/ID gets PC 8.
3. i_redirect=1, i_redirect_pc=0x43 while PC=0x10 -> next PC=0x40 and IF/ID is a bubble (valid=0, instr=0x00000013). The edge after that, IF/ID holds the instruction at 0x40.
4. i_stall=1 and i_flush=1 together, PC=0x20 -> PC holds at 0x20 and IF/ID becomes a bubble. With i_stall=1 and i_redirect=1 (target 0x80), PC=0x80.
5. RESET_PC=0xFFFF_FFF8, run 3 cycles -> o_imem_addr goes FFFF_FFF8, FFFF_FFFC, 0000_0000. IF/ID at PC FFFF_FFFC shows o_id_pc_plus4=0.
6. Drop i_rst_n mid-cycle at PC=0x30 with a valid instruction in IF/ID -> outputs reach reset values before the next clock edge. Releasing reset restarts fetch at RESET_PC.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared pipeline constants and the IF/ID record
package riscv_pkg;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] pc_plus4;
      logic [31:0] instr;
   } if_id_t;
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register with hold and bubble controls
module if_id_reg
   import riscv_pkg::*;
#(
   parameter logic [31:0] BUBBLE_INSTR = NOP_INSTR
) (
   input  logic   i_clk,
   input  logic   i_rst_n,
   input  logic   i_hold,
   input  logic   i_bubble,
   input  if_id_t i_d,
   output if_id_t o_q
);
   // a bubble keeps pc/pc_plus4 so only valid and instr change
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) o_q <= '{valid: 1'b0, pc: 32'd0, pc_plus4: 32'd0, instr: BUBBLE_INSTR};
      else if (i_bubble) begin
         o_q.valid <= 1'b0;
         o_q.instr <= BUBBLE_INSTR;
      end
      else if (!i_hold) o_q <= i_d;
endmodule

// File: rtl/if_stage.sv
// if_stage: program counter, next-PC selection and IF/ID capture
module if_stage
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   output logic [31:0] o_imem_addr,
   input  logic [31:0] i_imem_instr,
   input  logic        i_stall,
   input  logic        i_flush,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc,
   output logic        o_id_valid,
   output logic [31:0] o_id_pc,
   output logic [31:0] o_id_pc_plus4,
   output logic [31:0] o_id_instr
);
   logic [31:0] pc, pc_plus4;
   logic        unused_target_lsbs;
   if_id_t      id_q;
   assign pc_plus4           = pc + 32'd4;
   assign unused_target_lsbs = ^i_redirect_pc[1:0];
   // redirect outranks stall; targets are forced to word alignment
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) pc <= RESET_PC;
      else if (i_redirect) pc <= {i_redirect_pc[31:2], 2'b00};
      else if (!i_stall) pc <= pc_plus4;
   if_id_reg #(.BUBBLE_INSTR(NOP_INSTR)) u_if_id (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_hold  (i_stall),
      .i_bubble(i_redirect | i_flush),
      .i_d     ('{valid: 1'b1, pc: pc, pc_plus4: pc_plus4, instr: i_imem_instr}),
      .o_q     (id_q)
   );
   assign o_imem_addr   = pc;
   assign o_id_valid    = id_q.valid;
   assign o_id_pc       = id_q.pc;
   assign o_id_pc_plus4 = id_q.pc_plus4;
   assign o_id_instr    = id_q.instr;
endmodule
